// File: rtl/dmem_pkg.sv
// Shared types and widths for the D-cache block memory responder.
package dmem_pkg;

   localparam int ADDR_W  = 28;   // block address width (word address [29:2])
   localparam int BLOCK_W = 128;  // one cache block
   localparam int CNT_W   = 4;    // latency counter, covers LATENCY up to 15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2,
      TURN = 2'd3
   } dmem_state_t;

endpackage

// File: rtl/dmem_block_array.sv
// Single-port block store with registered read data. The array itself is
// never reset so it maps onto block RAM; only the read register is reset.
module dmem_block_array #(
   parameter int BLOCK_W    = dmem_pkg::BLOCK_W,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [BLOCK_W-1:0]    wdata,
   output logic [BLOCK_W-1:0]    rdata
);
   import dmem_pkg::*;

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [BLOCK_W-1:0] store_mem [DEPTH];
   logic [BLOCK_W-1:0] rdata_reg;

   // Write port: commit a block when the controller fires a write.
   always_ff @(posedge clk) begin
      if (we) begin
         store_mem[addr] <= wdata;
      end
   end

   // Read port: load only on a read fire so the output holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_reg <= '0;
      end else if (re) begin
         rdata_reg <= store_mem[addr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_block_responder.sv
// Memory-side responder for the D-cache block interface. Accepts one block
// read or write, waits a fixed LATENCY, pulses mem_ready for one cycle and
// then spends one turnaround cycle ignoring requests before going idle.
module dmem_block_responder #(
   parameter int ADDR_W     = dmem_pkg::ADDR_W,
   parameter int BLOCK_W    = dmem_pkg::BLOCK_W,
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 4   // legal range 1..15 (counter is 4 bits)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [ADDR_W-1:0]  mem_addr,
   input  logic [BLOCK_W-1:0] mem_wdata,
   output logic [BLOCK_W-1:0] mem_rdata,
   output logic               mem_ready,
   output logic               proto_err
);
   import dmem_pkg::*;

   dmem_state_t           state_reg;
   logic [CNT_W-1:0]      count_reg;
   logic                  op_write_reg;
   logic [DEPTH_LOG2-1:0] idx_reg;
   logic [BLOCK_W-1:0]    wdata_reg;
   logic                  ready_reg;
   logic                  proto_err_reg;

   logic                  arr_fire;
   logic                  arr_we;
   logic                  arr_re;

   // Upper address bits alias onto the same block; they are deliberately unused.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

   // The store is accessed on the last BUSY edge, so a write is in the array
   // before RESP and a following read can never see stale data.
   assign arr_fire = (state_reg == BUSY) && (count_reg == '0);
   assign arr_we   = arr_fire && op_write_reg;
   assign arr_re   = arr_fire && !op_write_reg;

   // Transaction FSM with latency counter, request capture and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         op_write_reg  <= 1'b0;
         idx_reg       <= '0;
         wdata_reg     <= '0;
         ready_reg     <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_read && mem_write) begin
                  // Ambiguous request: flag it and accept nothing.
                  proto_err_reg <= 1'b1;
               end else if (mem_read || mem_write) begin
                  op_write_reg <= mem_write;
                  idx_reg      <= mem_addr[DEPTH_LOG2-1:0];
                  wdata_reg    <= mem_wdata;
                  count_reg    <= CNT_W'(LATENCY - 1);
                  state_reg    <= BUSY;
               end
            end
            BUSY: begin
               if (count_reg == '0) begin
                  ready_reg <= 1'b1;
                  state_reg <= RESP;
               end else begin
                  count_reg <= count_reg - 1'b1;
               end
            end
            RESP: begin
               ready_reg <= 1'b0;
               state_reg <= TURN;
            end
            TURN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   dmem_block_array #(
      .BLOCK_W    (BLOCK_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (idx_reg),
      .wdata (wdata_reg),
      .rdata (mem_rdata)
   );

   assign mem_ready = ready_reg;
   assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Bench for dmem_block_responder: directed table, hand-written corner
// sequences and randomized traffic against an associative-array memory model.
module tb_dmem_block_responder;

   localparam int LAT = 4;

   logic         clk;
   logic         rst_n;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic         proto_err;

   int checks   = 0;
   int failures = 0;
   int txn_no   = 0;

   // Reference model: block contents keyed by aliased index, plus the value
   // mem_rdata is expected to hold between reads.
   logic [127:0] model [int];
   int           keys_q [$];
   logic [127:0] exp_hold;

   dmem_block_responder #(
      .ADDR_W     (28),
      .BLOCK_W    (128),
      .DEPTH_LOG2 (8),
      .LATENCY    (LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int idx_of(input logic [27:0] a);
      return int'(a) % 256;
   endfunction

   task automatic model_write(input logic [27:0] a, input logic [127:0] d);
      if (!model.exists(idx_of(a))) keys_q.push_back(idx_of(a));
      model[idx_of(a)] = d;
   endtask

   // One transaction as a well-behaved initiator: request from cycle 0, drop
   // it the cycle after mem_ready (or in BUSY when drop=1). Called at a negedge.
   task automatic run_txn(input string tag, input bit wr, input logic [27:0] addr,
                          input logic [127:0] data, input bit drop, input logic [127:0] exp_rd);
      int           rdy_cycle;
      int           rdy_count;
      bit           prev_rdy;
      logic [127:0] rd_at_rdy;
      rdy_cycle = -1;
      rdy_count = 0;
      prev_rdy  = 1'b0;
      rd_at_rdy = '0;
      mem_read  = !wr;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = data;
      for (int c = 1; c <= LAT + 6; c++) begin
         @(posedge clk);
         #1;
         if (prev_rdy || (drop && c == 2)) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_wdata = ~data;
            mem_addr  = addr ^ 28'h1;
         end
         @(negedge clk);
         prev_rdy = mem_ready;
         if (mem_ready) begin
            rdy_count++;
            if (rdy_cycle < 0) begin
               rdy_cycle = c;
               rd_at_rdy = mem_rdata;
            end
         end
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (!wr) exp_hold = exp_rd;
      chk_int({tag, " ready_cycle"}, rdy_cycle, LAT + 1);
      chk_int({tag, " ready_count"}, rdy_count, 1);
      if (!wr) chk({tag, " rdata"}, rd_at_rdy, exp_rd);
      chk({tag, " rdata_hold"}, mem_rdata, exp_hold);
      $display("txn %0d %s %s addr=%h wdata=%h drop=%0d ready_cycle=%0d rdata=%h",
               txn_no, tag, wr ? "WR" : "RD", addr, data, drop, rdy_cycle, mem_rdata);
      txn_no++;
   endtask

   typedef struct {
      bit           wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
      bit           drop;
      logic [127:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int           rdy;
      logic [127:0] blk_a;
      logic [127:0] rnd_d;
      logic [27:0]  rnd_a;
      int           ridx;

      blk_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

      vecs[0] = '{1'b1, 28'h0000012, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 128'h0};
      vecs[1] = '{1'b0, 28'h0000012, 128'h0, 1'b0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
      vecs[2] = '{1'b1, 28'h0000105, 128'h1, 1'b0, 128'h0};
      vecs[3] = '{1'b0, 28'h0000005, 128'h0, 1'b0, 128'h1};
      vecs[4] = '{1'b1, 28'h0000003, blk_a, 1'b1, 128'h0};
      vecs[5] = '{1'b0, 28'h0000003, 128'h0, 1'b0, blk_a};

      // Reset then idle
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      exp_hold  = '0;
      repeat (3) @(negedge clk);
      chk("reset mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("reset mem_rdata", mem_rdata, 128'd0);
      chk("reset proto_err", {127'd0, proto_err}, 128'd0);
      rst_n = 1'b1;
      rdy = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_ready) rdy++;
      end
      chk_int("idle ready_pulses", rdy, 0);
      chk("idle mem_rdata", mem_rdata, 128'd0);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].drop, vecs[i].exp_rd);
         if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata);
      end

      // Protocol error: both requests for one cycle in IDLE
      mem_read  = 1'b1;
      mem_write = 1'b1;
      mem_addr  = 28'h0000012;
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("proto_err set", {127'd0, proto_err}, 128'd1);
      rdy = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_ready) rdy++;
      end
      chk_int("proto ready_pulses", rdy, 0);
      chk("proto_err sticky", {127'd0, proto_err}, 128'd1);
      run_txn("after_proto", 1'b0, 28'h0000012, 128'h0, 1'b0, model[idx_of(28'h12)]);
      chk("proto_err still", {127'd0, proto_err}, 128'd1);

      // Reset mid-write: prior contents 9, aborted write of 5
      run_txn("pre_reset", 1'b1, 28'h0000007, 128'h9, 1'b0, 128'h0);
      model_write(28'h0000007, 128'h9);
      mem_write = 1'b1;
      mem_addr  = 28'h0000007;
      mem_wdata = 128'h5;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset mem_ready", {127'd0, mem_ready}, 128'd0);
      mem_write = 1'b0;
      rdy = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (mem_ready) rdy++;
      end
      chk_int("midreset ready_pulses", rdy, 0);
      exp_hold = '0;
      chk("midreset mem_rdata", mem_rdata, 128'd0);
      chk("midreset proto_err", {127'd0, proto_err}, 128'd0);
      run_txn("after_reset", 1'b0, 28'h0000007, 128'h0, 1'b0, 128'h9);

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         bit do_wr;
         bit drop;
         do_wr = (keys_q.size() == 0) || ($urandom_range(1, 0) == 1);
         drop  = ($urandom_range(3, 0) == 0);
         if (do_wr) begin
            rnd_a = 28'($urandom);
            rnd_d = {$urandom, $urandom, $urandom, $urandom};
            run_txn($sformatf("rnd%0d", n), 1'b1, rnd_a, rnd_d, drop, 128'h0);
            model_write(rnd_a, rnd_d);
         end else begin
            ridx  = keys_q[$urandom_range(keys_q.size() - 1, 0)];
            rnd_a = {20'($urandom), 8'(ridx)};
            run_txn($sformatf("rnd%0d", n), 1'b0, rnd_a, 128'h0, drop, model[ridx]);
         end
      end
      chk("final proto_err", {127'd0, proto_err}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
